// File: rtl/magma_round_sched_if.sv
// Round-function port pair between the Magma round sequencer and the
// combinational g(a0, k) = rotl11(S(a0 + k)) unit.
//   f_in  : current a0 word, sequencer -> round unit
//   f_key : current subkey, sequencer -> round unit
//   f_out : g(f_in, f_key), round unit -> sequencer
// master = sequencer side, slave = round-unit side.
interface magma_round_sched_if;
  logic [31:0] f_in;
  logic [31:0] f_key;
  logic [31:0] f_out;

  modport master (output f_in, output f_key, input f_out);
  modport slave  (input f_in, input f_key, output f_out);
endinterface

// File: rtl/magma_round_sched.sv
// Magma (GOST R 34.12-2015) round sequencer: holds the 256-bit key and the
// 64-bit block state, runs 32 Feistel rounds (one per cycle, or one per step
// pulse) and orders the subkeys for encryption or decryption. The S-box/add/
// rotate round function is external and reached through f_bus.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   key_load, key_in     : key capture pulse and key (K0 = [255:224] .. K7 = [31:0])
//   start, blk_in        : operation start pulse and input block (a1 = [63:32])
//   decrypt, step_mode   : mode bits, sampled with start
//   step                 : single-round advance pulse (step_mode only)
//   f_bus                : round-function port pair (master side)
//   busy, done           : RUN indicator, one-cycle result-valid pulse
//   rnd                  : current round index 0..31
//   blk_out              : result, held until the next done
module magma_round_sched (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_load,
  input  logic [255:0]         key_in,
  input  logic                 start,
  input  logic [63:0]          blk_in,
  input  logic                 decrypt,
  input  logic                 step_mode,
  input  logic                 step,
  magma_round_sched_if.master  f_bus,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           rnd,
  output logic [63:0]          blk_out
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [255:0] key_q, key_d;
  logic [31:0]  a1_q, a1_d;
  logic [31:0]  a0_q, a0_d;
  logic         decrypt_q, decrypt_d;
  logic         step_mode_q, step_mode_d;
  logic [4:0]   rnd_q, rnd_d;
  logic         done_q, done_d;
  logic [63:0]  blk_out_q, blk_out_d;

  logic         advance;
  logic         last_round;
  logic         key_rev;
  logic [2:0]   key_idx;
  logic [31:0]  sub_k [8];
  logic [31:0]  f_xor;

  assign advance    = step_mode_q ? step : 1'b1;
  assign last_round = (rnd_q == 5'd31);
  assign f_xor      = f_bus.f_out ^ a1_q;

  // Subkey order: the descending runs (7..0) are the ascending index inverted.
  // Encrypt descends only in the last 8 rounds, decrypt in all but the first 8.
  assign key_rev = decrypt_q ? (rnd_q >= 5'd8) : (rnd_q >= 5'd24);
  assign key_idx = key_rev ? ~rnd_q[2:0] : rnd_q[2:0];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      sub_k[i] = key_q[32*(7-i) +: 32];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (advance && last_round) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values driven by the current state
  always_comb begin
    key_d       = key_q;
    a1_d        = a1_q;
    a0_d        = a0_q;
    decrypt_d   = decrypt_q;
    step_mode_d = step_mode_q;
    rnd_d       = rnd_q;
    blk_out_d   = blk_out_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        // The key written here is what the rounds read from E1 onward, so a
        // simultaneous key_load + start uses the new key.
        if (key_load) key_d = key_in;
        if (start) begin
          a1_d        = blk_in[63:32];
          a0_d        = blk_in[31:0];
          decrypt_d   = decrypt;
          step_mode_d = step_mode;
          rnd_d       = 5'd0;
        end
      end
      StRun: begin
        if (advance) begin
          if (last_round) begin
            // Final round has no swap.
            blk_out_d = {f_xor, a0_q};
            done_d    = 1'b1;
            rnd_d     = 5'd0;
          end else begin
            a1_d  = a0_q;
            a0_d  = f_xor;
            rnd_d = rnd_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q       <= '0;
      a1_q        <= '0;
      a0_q        <= '0;
      decrypt_q   <= 1'b0;
      step_mode_q <= 1'b0;
      rnd_q       <= '0;
      done_q      <= 1'b0;
      blk_out_q   <= '0;
    end else begin
      key_q       <= key_d;
      a1_q        <= a1_d;
      a0_q        <= a0_d;
      decrypt_q   <= decrypt_d;
      step_mode_q <= step_mode_d;
      rnd_q       <= rnd_d;
      done_q      <= done_d;
      blk_out_q   <= blk_out_d;
    end
  end

  assign busy        = (state_q == StRun);
  assign done        = done_q;
  assign rnd         = rnd_q;
  assign blk_out     = blk_out_q;
  assign f_bus.f_in  = a0_q;
  assign f_bus.f_key = sub_k[key_idx];

endmodule

// File: tb/tb_magma_round_sched.sv
// Directed bench for magma_round_sched: stub and real round units, key
// schedule order, step mode, dropped inputs during RUN and reset abort.
module tb_magma_round_sched;

  localparam logic [255:0] RealKey =
    256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0] Pt = 64'hfedcba9876543210;
  localparam logic [63:0] Ct = 64'h4ee901e5c2d8ca3d;

  // Magma S-boxes, Pi0..Pi7, entry 0 in the top nibble.
  localparam logic [63:0] Pi [8] = '{
    64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F, 64'hB3582FADE174C960,
    64'hC821D4F670A53E9B, 64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0,
    64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
  };

  logic         clk;
  logic         reset;
  logic         key_load;
  logic [255:0] key_in;
  logic         start;
  logic [63:0]  blk_in;
  logic         decrypt;
  logic         step_mode;
  logic         step;
  logic         busy;
  logic         done;
  logic [4:0]   rnd;
  logic [63:0]  blk_out;

  logic         use_real;
  logic [31:0]  f_model;
  bit           done_seen;
  int           passed;
  int           total;

  magma_round_sched_if rif ();

  magma_round_sched dut (
    .clk       (clk),
    .reset     (reset),
    .key_load  (key_load),
    .key_in    (key_in),
    .start     (start),
    .blk_in    (blk_in),
    .decrypt   (decrypt),
    .step_mode (step_mode),
    .step      (step),
    .f_bus     (rif),
    .busy      (busy),
    .done      (done),
    .rnd       (rnd),
    .blk_out   (blk_out)
  );

  function automatic logic [31:0] g_fn(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] s;
    logic [31:0] t;
    logic [63:0] row;
    logic [3:0]  nib;
    s = a + k;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      row = Pi[i];
      nib = s[4*i +: 4];
      t[4*i +: 4] = row[4*(15 - int'(nib)) +: 4];
    end
    return {t[20:0], t[31:21]};
  endfunction

  always_comb begin
    if (use_real) f_model = g_fn(rif.f_in, rif.f_key);
    else          f_model = rif.f_in ^ rif.f_key;
  end
  assign rif.f_out = f_model;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen = 1'b1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic do_start(input logic [63:0] blk, input logic dec, input logic sm);
    start     = 1'b1;
    blk_in    = blk;
    decrypt   = dec;
    step_mode = sm;
    tick();
    start     = 1'b0;
    key_load  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic load_key(input logic [255:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic step_pulse();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    int n;
    int bcnt;
    int exp_idx;
    passed    = 0;
    total     = 0;
    done_seen = 1'b0;
    use_real  = 1'b0;
    key_load  = 1'b0;
    key_in    = '0;
    start     = 1'b0;
    blk_in    = '0;
    decrypt   = 1'b0;
    step_mode = 1'b0;
    step      = 1'b0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rnd", 64'(rnd), 64'd0);
    check("rst_blk_out", blk_out, 64'd0);
    check("rst_f_in", 64'(rif.f_in), 64'd0);
    reset = 1'b0;

    // Stub round unit, zero key: 33-cycle latency, 32 busy cycles
    do_start(64'h123456789ABCDEF0, 1'b0, 1'b0);
    n = 0;
    bcnt = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) bcnt++;
      tick();
      n++;
    end
    check("stub_latency", 64'(n + 1), 64'd33);
    check("stub_busy_cycles", 64'(bcnt), 64'd32);
    check("stub_busy_at_done", 64'(busy), 64'd0);
    check("stub_result", blk_out, 64'h12345678_88888888);
    tick();
    check("stub_done_pulse", 64'(done), 64'd0);
    check("stub_result_held", blk_out, 64'h12345678_88888888);

    // Key schedule with K_i = i
    load_key({32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7});
    do_start(64'h0, 1'b0, 1'b0);
    for (int r = 0; r < 32; r++) begin
      exp_idx = (r < 24) ? (r % 8) : (31 - r);
      check("enc_sched", {27'd0, rnd, f_model ^ f_model, rif.f_key},
            {27'd0, 5'(r), 32'd0, 32'(exp_idx)});
      tick();
    end
    check("enc_sched_done", 64'(done), 64'd1);
    do_start(64'h0, 1'b1, 1'b0);
    for (int r = 0; r < 32; r++) begin
      exp_idx = (r < 8) ? r : (7 - (r % 8));
      check("dec_sched", {27'd0, rnd, rif.f_key}, {27'd0, 5'(r), 32'(exp_idx)});
      tick();
    end
    check("dec_sched_done", 64'(done), 64'd1);

    // Real round unit: known-answer encrypt, then back-to-back decrypt
    use_real = 1'b1;
    load_key(RealKey);
    check("idle_f_key_k0", 64'(rif.f_key), 64'hffeeddcc);
    do_start(Pt, 1'b0, 1'b0);
    wait_done(n);
    check("kat_enc_done", 64'(done), 64'd1);
    check("kat_enc", blk_out, Ct);
    do_start(Ct, 1'b1, 1'b0);
    wait_done(n);
    check("kat_dec_latency", 64'(n + 1), 64'd33);
    check("kat_dec", blk_out, Pt);

    // Step mode: pulses in IDLE do nothing
    for (int i = 0; i < 3; i++) begin
      step_pulse();
      tick();
    end
    check("idle_step_busy", 64'(busy), 64'd0);
    check("idle_step_rnd", 64'(rnd), 64'd0);
    check("idle_step_blk", blk_out, Pt);
    do_start(Pt, 1'b0, 1'b1);
    done_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step_pulse();
      tick();
      tick();
    end
    check("step10_rnd", 64'(rnd), 64'd10);
    check("step10_busy", 64'(busy), 64'd1);
    check("step10_no_done", 64'(done_seen), 64'd0);
    for (int i = 0; i < 21; i++) begin
      step_pulse();
      tick();
    end
    check("step31_no_done", 64'(done_seen), 64'd0);
    step_pulse();
    check("step32_done", 64'(done), 64'd1);
    check("step32_result", blk_out, Ct);
    check("step32_busy", 64'(busy), 64'd0);

    // start / key_load during RUN are dropped
    do_start(Pt, 1'b0, 1'b0);
    repeat (5) tick();
    start    = 1'b1;
    blk_in   = 64'h0;
    key_load = 1'b1;
    key_in   = '0;
    tick();
    start    = 1'b0;
    key_load = 1'b0;
    wait_done(n);
    check("ignored_result", blk_out, Ct);
    tick();
    check("ignored_key_kept", 64'(rif.f_key), 64'hffeeddcc);
    check("ignored_not_busy", 64'(busy), 64'd0);

    // Simultaneous key_load + start uses the new key
    load_key('0);
    check("zero_key_loaded", 64'(rif.f_key), 64'd0);
    key_in   = RealKey;
    key_load = 1'b1;
    do_start(Pt, 1'b0, 1'b0);
    wait_done(n);
    check("simul_key_result", blk_out, Ct);

    // Reset abort at round 15
    do_start(Pt, 1'b0, 1'b0);
    n = 0;
    while (rnd !== 5'd15 && n < 100) begin
      tick();
      n++;
    end
    check("abort_reached_r15", 64'(rnd), 64'd15);
    reset     = 1'b1;
    done_seen = 1'b0;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_blk_out", blk_out, 64'd0);
    check("abort_rnd", 64'(rnd), 64'd0);
    repeat (40) tick();
    check("abort_no_done", 64'(done_seen), 64'd0);
    load_key(RealKey);
    do_start(Pt, 1'b0, 1'b0);
    wait_done(n);
    check("abort_restart_latency", 64'(n + 1), 64'd33);
    check("abort_restart_result", blk_out, Ct);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/magma_round_sched.md
# magma_round_sched

Round sequencer for the Magma (GOST R 34.12-2015, 64-bit block, 256-bit key) core behind the board data-entry driver. It holds the key and block state and runs 32 Feistel rounds, one per cycle or one per step pulse. It generates the per-round subkey order for encryption and decryption. The substitution/add/rotate round function sits in a separate combinational unit reached through the `f_*` port pair.

## Interface
- No parameters.
- `clk` — input, 1 — clock.
- `reset` — input, 1 — synchronous, active-high.
- `key_load` — input, 1 — one-cycle pulse; captures `key_in` when idle.
- `key_in` — input, 256 — key; K0 = [255:224] … K7 = [31:0].
- `start` — input, 1 — one-cycle pulse; captures `blk_in` and `decrypt` when idle.
- `blk_in` — input, 64 — input block; a1 = [63:32], a0 = [31:0].
- `decrypt` — input, 1 — 0 = encrypt, 1 = decrypt; sampled with `start`.
- `step_mode` — input, 1 — 1 = advance one round per `step` pulse; sampled with `start`.
- `step` — input, 1 — one-cycle pulse, already debounced and edge-detected upstream.
- `f_in` — output, 32 — current a0 sent to the round unit.
- `f_key` — output, 32 — current subkey.
- `f_out` — input, 32 — g(a0, k) = rotl11(S(a0 + k mod 2^32)), combinational.
- `busy` — output, 1 — high while in RUN.
- `done` — output, 1 — one-cycle pulse when the result is valid.
- `rnd` — output, 5 — current round index 0..31, for the display.
- `blk_out` — output, 64 — result, held until the next `done`.

## Operation
- **States**:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
- **IDLE**:
  - `key_load` writes the key register.
  - `start` loads a1/a0 and latches mode and step_mode, sets `rnd`=0, and goes to RUN.
  - If `key_load` and `start` arrive in the same cycle: the new key is loaded and used for this operation.
- **RUN, advance condition**: every cycle when step_mode=0; only on a `step` pulse when step_mode=1.
- **Advance, rounds 0..30**: (a1,a0) ← (a0, f_out ^ a1); `rnd` += 1.
- **Advance, round 31**:
  - `blk_out` ← {f_out ^ a1, a0} (no swap).
  - `done`=1 in the following cycle.
  - Return to IDLE; `rnd` returns to 0.
- **Subkey index i for round r**:
  - encrypt: i = r mod 8 for r < 24, else 31 − r;
  - decrypt: i = r for r < 8, else 7 − (r mod 8).
  - `f_key` = K_i.
- **`f_in`**: always equals the a0 register; `f_key` is driven in IDLE too, at index 0.
- **Ignored inputs**:
  - `start` and `key_load` during RUN are dropped; no queueing.
  - `step` in IDLE or with step_mode=0 is ignored.
- **Arithmetic**: all XORs are 32-bit; the block performs no modular add itself, the round unit does.
- **Reset values**: state IDLE; `busy`=0, `done`=0, `rnd`=0, `blk_out`=0, key=0, a1=a0=0, latched mode=0.
- **Reset mid-RUN**: the operation aborts immediately, no `done` is produced, and `blk_out` is cleared to 0.

## Timing
- `start` is sampled at edge E0, and `busy` is 1 from the cycle after E0.
- step_mode=0:
  - rounds are applied at edges E1..E32;
  - `blk_out` is valid and `done`=1 in the cycle after E32;
  - `busy`=0 in that same cycle;
  - total latency from `start` to `done` is 33 cycles.
- A new `start` is accepted in the `done` cycle, giving back-to-back throughput of one block per 33 cycles.
- step_mode=1: `done` asserts one cycle after the 32nd accepted `step`.
- All outputs are registered, except `f_in` and `f_key`, which decode from registers through a combinational subkey mux.

## Test plan
- **Stub round unit**, with bench f_out = f_in ^ f_key and key = 0:
  - `start`, blk_in = 0x12345678_9ABCDEF0, encrypt;
  - expect `done` exactly 33 cycles later with `blk_out` = 0x12345678_88888888;
  - expect `busy` high for 32 cycles.
- **Key schedule**, with K_i = i:
  - encrypt: `f_key` sequence over the 32 rounds is 0..7, 0..7, 0..7, 7..0;
  - decrypt: sequence is 0..7, 7..0, 7..0, 7..0;
  - `rnd` counts 0..31 in both cases.
- **Real round unit**:
  - key = 0xffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  - encrypt 0xfedcba9876543210 → 0x4ee901e5c2d8ca3d;
  - decrypt of that result → original plaintext.
- **Step mode**:
  - issue `start` with step_mode=1, then 10 `step` pulses with idle gaps;
  - expect `rnd`=10, `busy`=1, no `done`;
  - 22 more pulses → `done` and the same result as the free-running case;
  - pulses arriving during IDLE have no effect.
- **Ignored inputs**:
  - `start` and `key_load` issued mid-RUN → result unchanged and key register unchanged.
  - Simultaneous `key_load` + `start` in IDLE → the new key is used.
- **Reset abort**:
  - assert `reset` at round 15;
  - expect `busy`=0, `blk_out`=0, no `done` pulse, and `rnd`=0 on the next cycle;
  - a following `start` completes normally.
